univ_shiftreg: RTL and testbench

Parametrised universal shift register: parallel load, shift left/right with serial in, rotate left/right, and an autonomous burst mode that shifts a programmed number of times and then pulses `done`. It is the general-purpose successor to the 4-bit load/shift register. It serves as a serializer/deserializer or rotator building block inside the datapath, sitting between a parallel producer and a serial consumer.

---
 rtl/univ_shiftreg_if.sv | 30 +++
 rtl/univ_shiftreg.sv | 99 +++++++++
 tb/tb_univ_shiftreg.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/univ_shiftreg_if.sv
// Bus bundle for the universal shift register.
// Master drives control and data; slave returns register state.
interface univ_shiftreg_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             load_en;
    logic [WIDTH-1:0] load;
    logic             shift_en;
    logic [1:0]       mode;
    logic             shift_in;
    logic             burst_start;
    logic [CNT_W-1:0] burst_len;
    logic [WIDTH-1:0] regout;
    logic             shift_out;
    logic             busy;
    logic             done;

    modport master (
        output load_en, load, shift_en, mode, shift_in,
        output burst_start, burst_len,
        input  regout, shift_out, busy, done
    );

    modport slave (
        input  load_en, load, shift_en, mode, shift_in,
        input  burst_start, burst_len,
        output regout, shift_out, busy, done
    );
endinterface

// File: rtl/univ_shiftreg.sv
// Universal shift register: load, shift, rotate and
// counted autonomous bursts that pulse done on completion.
module univ_shiftreg #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input logic            clk,
    input logic            rst_n,
    univ_shiftreg_if.slave bus
);
    typedef enum logic {IDLE, BURST} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       bmode_q, bmode_d;
    logic             done_q, done_d;
    logic [1:0]       eff_mode;

    function automatic logic [WIDTH-1:0] shf(
        input logic [WIDTH-1:0] r,
        input logic [1:0]       m,
        input logic             si
    );
        logic [WIDTH-1:0] res;
        unique case (m)
            2'b00: res = {r[WIDTH-2:0], si};
            2'b01: res = {si, r[WIDTH-1:1]};
            2'b10: res = {r[WIDTH-2:0], r[WIDTH-1]};
            2'b11: res = {r[0], r[WIDTH-1:1]};
            default: res = r;
        endcase
        return res;
    endfunction

    // Mode is frozen for the whole burst
    assign eff_mode = (state_q == BURST) ? bmode_q : bus.mode;

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        bmode_d = bmode_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.load_en) begin
                    r_d = bus.load;
                end else if (bus.burst_start) begin
                    if (bus.burst_len != '0) begin
                        cnt_d   = bus.burst_len;
                        bmode_d = bus.mode;
                        state_d = BURST;
                    end else begin
                        done_d = 1'b1;
                    end
                end else if (bus.shift_en) begin
                    r_d = shf(r_q, bus.mode, bus.shift_in);
                end
            end
            BURST: begin
                if (bus.load_en) begin
                    r_d     = bus.load;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    r_d   = shf(r_q, bmode_q, bus.shift_in);
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == 1) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            r_q     <= '0;
            cnt_q   <= '0;
            bmode_q <= 2'b00;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            bmode_q <= bmode_d;
            done_q  <= done_d;
        end
    end

    assign bus.regout    = r_q;
    assign bus.busy      = (state_q == BURST);
    assign bus.done      = done_q;
    assign bus.shift_out = eff_mode[0] ? r_q[0] : r_q[WIDTH-1];
endmodule

// File: tb/tb_univ_shiftreg.sv
// Directed vector bench for univ_shiftreg (WIDTH=4).
// Table of per-edge vectors plus hand sequences for abort/reset.
module tb_univ_shiftreg;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    univ_shiftreg_if #(.WIDTH(4), .CNT_W(8)) bus ();

    univ_shiftreg #(.WIDTH(4), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       le;
        logic [3:0] ld;
        logic       se;
        logic [1:0] md;
        logic       si;
        logic       bs;
        logic [7:0] bl;
        logic       eso;
        logic [3:0] er;
        logic       eb;
        logic       ed;
    } vec_t;

    vec_t vecs[19];

    function automatic vec_t v(
        input logic le, input logic [3:0] ld,
        input logic se, input logic [1:0] md,
        input logic si, input logic bs,
        input logic [7:0] bl, input logic eso,
        input logic [3:0] er, input logic eb,
        input logic ed
    );
        vec_t t;
        t.le = le; t.ld = ld; t.se = se; t.md = md;
        t.si = si; t.bs = bs; t.bl = bl; t.eso = eso;
        t.er = er; t.eb = eb; t.ed = ed;
        return t;
    endfunction

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h",
                     nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic le, input logic [3:0] ld,
                         input logic se, input logic [1:0] md,
                         input logic si, input logic bs,
                         input logic [7:0] bl);
        bus.load_en     = le;
        bus.load        = ld;
        bus.shift_en    = se;
        bus.mode        = md;
        bus.shift_in    = si;
        bus.burst_start = bs;
        bus.burst_len   = bl;
    endtask

    task automatic idle();
        drive(0, 4'h0, 0, 2'b00, 0, 0, 8'd0);
    endtask

    task automatic chk_out(input string nm, input logic [3:0] r,
                           input logic b, input logic d);
        chk({nm, ".reg"}, 32'(bus.regout), 32'(r));
        chk({nm, ".busy"}, 32'(bus.busy), 32'(b));
        chk({nm, ".done"}, 32'(bus.done), 32'(d));
    endtask

    initial begin
        //          le ld      se md     si bs bl    so reg     b d
        vecs[0]  = v(1, 4'hA, 0, 2'b00, 0, 0, 8'd0, 0, 4'hA, 0, 0);
        vecs[1]  = v(0, 4'h0, 1, 2'b00, 1, 0, 8'd0, 1, 4'h5, 0, 0);
        vecs[2]  = v(0, 4'h0, 1, 2'b00, 0, 0, 8'd0, 0, 4'hA, 0, 0);
        vecs[3]  = v(0, 4'h0, 1, 2'b00, 1, 0, 8'd0, 1, 4'h5, 0, 0);
        vecs[4]  = v(0, 4'h0, 1, 2'b00, 0, 0, 8'd0, 0, 4'hA, 0, 0);
        vecs[5]  = v(1, 4'hA, 0, 2'b01, 0, 0, 8'd0, 0, 4'hA, 0, 0);
        vecs[6]  = v(0, 4'h0, 1, 2'b01, 1, 0, 8'd0, 0, 4'hD, 0, 0);
        vecs[7]  = v(0, 4'h0, 1, 2'b01, 0, 0, 8'd0, 1, 4'h6, 0, 0);
        vecs[8]  = v(1, 4'h9, 0, 2'b10, 0, 0, 8'd0, 0, 4'h9, 0, 0);
        vecs[9]  = v(0, 4'h0, 1, 2'b10, 0, 0, 8'd0, 1, 4'h3, 0, 0);
        vecs[10] = v(0, 4'h0, 1, 2'b10, 0, 0, 8'd0, 0, 4'h6, 0, 0);
        vecs[11] = v(0, 4'h0, 1, 2'b10, 0, 0, 8'd0, 0, 4'hC, 0, 0);
        vecs[12] = v(0, 4'h0, 1, 2'b10, 0, 0, 8'd0, 1, 4'h9, 0, 0);
        vecs[13] = v(1, 4'h8, 0, 2'b11, 0, 0, 8'd0, 1, 4'h8, 0, 0);
        vecs[14] = v(0, 4'h0, 0, 2'b11, 0, 1, 8'd3, 0, 4'h8, 1, 0);
        vecs[15] = v(0, 4'h0, 0, 2'b00, 1, 0, 8'd0, 0, 4'h4, 1, 0);
        vecs[16] = v(0, 4'h0, 1, 2'b00, 1, 0, 8'd0, 0, 4'h2, 1, 0);
        vecs[17] = v(0, 4'h0, 0, 2'b00, 1, 1, 8'd3, 0, 4'h1, 0, 1);
        vecs[18] = v(0, 4'h0, 0, 2'b00, 0, 0, 8'd0, 0, 4'h1, 0, 0);

        idle();
        #12;
        chk_out("rst_low", 4'h0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_out("rst_rel", 4'h0, 0, 0);

        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].le, vecs[i].ld, vecs[i].se, vecs[i].md,
                  vecs[i].si, vecs[i].bs, vecs[i].bl);
            #1;
            chk($sformatf("v%0d.so", i), 32'(bus.shift_out),
                32'(vecs[i].eso));
            tick();
            chk_out($sformatf("v%0d", i), vecs[i].er,
                    vecs[i].eb, vecs[i].ed);
        end

        // Abort: burst of 5 rotating left, load at third edge
        drive(1, 4'h1, 0, 2'b10, 0, 0, 8'd0);
        tick();
        drive(0, 4'h0, 0, 2'b10, 0, 1, 8'd5);
        tick();
        chk_out("ab.start", 4'h1, 1, 0);
        idle();
        tick();
        chk_out("ab.e1", 4'h2, 1, 0);
        tick();
        chk_out("ab.e2", 4'h4, 1, 0);
        drive(1, 4'hF, 0, 2'b00, 0, 0, 8'd0);
        tick();
        chk_out("ab.load", 4'hF, 0, 0);
        idle();
        tick();
        chk_out("ab.after", 4'hF, 0, 0);

        // Zero-length burst
        drive(0, 4'h0, 0, 2'b01, 0, 1, 8'd0);
        tick();
        chk_out("z.pulse", 4'hF, 0, 1);
        idle();
        tick();
        chk_out("z.after", 4'hF, 0, 0);

        // Load wins over simultaneous burst start
        drive(1, 4'h6, 0, 2'b10, 0, 1, 8'd2);
        tick();
        chk_out("lw", 4'h6, 0, 0);

        // Asynchronous reset mid-burst
        drive(1, 4'h5, 0, 2'b10, 0, 0, 8'd0);
        tick();
        drive(0, 4'h0, 0, 2'b10, 0, 1, 8'd4);
        tick();
        idle();
        tick();
        chk_out("mr.run", 4'hA, 1, 0);
        #2 rst_n = 1'b0;
        #1;
        chk_out("mr.rst", 4'h0, 0, 0);
        #1 rst_n = 1'b1;
        drive(1, 4'h3, 0, 2'b10, 0, 0, 8'd0);
        tick();
        chk_out("mr.load", 4'h3, 0, 0);
        drive(0, 4'h0, 0, 2'b10, 0, 1, 8'd2);
        tick();
        chk_out("mr.start", 4'h3, 1, 0);
        idle();
        tick();
        chk_out("mr.e1", 4'h6, 1, 0);
        tick();
        chk_out("mr.e2", 4'hC, 0, 1);
        tick();
        chk_out("mr.after", 4'hC, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end
endmodule
